// File: rtl/gray_bin_decoder.sv
// Two-stage registered Gray-to-binary decoder with step classification,
// lock tracking and a saturating step-error counter.
module gray_bin_decoder #(
    parameter int Width = 3,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [Width-1:0] G_IN,
    input  logic             G_VALID,
    input  logic             CLR_ERR,
    output logic [Width-1:0] B_OUT,
    output logic             B_VALID,
    output logic             UP,
    output logic             DN,
    output logic             STEP_ERR,
    output logic             LOCK,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [Width-1:0] r_gReg;
    logic             r_v1;
    logic [Width-1:0] r_prevB;
    logic [Width-1:0] w_bin;
    logic [Width-1:0] w_diff;
    logic             w_isUp;
    logic             w_isDn;
    logic             w_isHold;
    logic             w_classify;
    logic             w_up;
    logic             w_dn;
    logic             w_err;

    // Stage 1: capture the qualified Gray sample
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gReg <= '0;
            r_v1   <= 1'b0;
        end else begin
            r_v1 <= G_VALID;
            if (G_VALID) begin
                r_gReg <= G_IN;
            end
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < Width; i++) begin
            w_bin[i] = ^(r_gReg >> i);
        end
    end

    assign w_diff     = w_bin - r_prevB;
    assign w_isUp     = (w_diff == Width'(1));
    assign w_isDn     = (w_diff == {Width{1'b1}});
    assign w_isHold   = (w_diff == '0);
    assign w_classify = r_v1 && (r_state != EMPTY);

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: only decoded samples move it
    always_comb begin
        w_nextState = r_state;
        if (r_v1) begin
            case (r_state)
                EMPTY:   w_nextState = LOCKED;
                LOCKED:  w_nextState = (w_isUp || w_isDn || w_isHold) ? LOCKED : FAULT;
                FAULT:   w_nextState = (w_isUp || w_isDn || w_isHold) ? LOCKED : FAULT;
                default: w_nextState = EMPTY;
            endcase
        end
    end

    // FSM outputs: step flags are only meaningful once a reference exists
    always_comb begin
        w_up  = w_classify && w_isUp;
        w_dn  = w_classify && w_isDn;
        w_err = w_classify && !(w_isUp || w_isDn || w_isHold);
    end

    // Stage 2: registered results, previous value and lock indication
    always_ff @(posedge CLK) begin
        if (RST) begin
            B_OUT    <= '0;
            B_VALID  <= 1'b0;
            UP       <= 1'b0;
            DN       <= 1'b0;
            STEP_ERR <= 1'b0;
            LOCK     <= 1'b0;
            r_prevB  <= '0;
        end else begin
            B_VALID  <= r_v1;
            UP       <= w_up;
            DN       <= w_dn;
            STEP_ERR <= w_err;
            LOCK     <= (w_nextState == LOCKED);
            if (r_v1) begin
                B_OUT   <= w_bin;
                r_prevB <= w_bin;
            end
        end
    end

    // Saturating error counter; a clear beats a coincident error
    always_ff @(posedge CLK) begin
        if (RST || CLR_ERR) begin
            ERR_CNT <= '0;
        end else if (w_err && (ERR_CNT != {ERR_W{1'b1}})) begin
            ERR_CNT <= ERR_CNT + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_bin_decoder.sv
// Randomised and directed bench for gray_bin_decoder against a sample-level
// reference model that decodes Gray words by searching the code table.
module tb_gray_bin_decoder;

    localparam int Width  = 3;
    localparam int ERR_W  = 8;
    localparam int Mask   = (1 << Width) - 1;
    localparam int ErrMax = (1 << ERR_W) - 1;

    logic             CLK;
    logic             RST;
    logic [Width-1:0] G_IN;
    logic             G_VALID;
    logic             CLR_ERR;
    logic [Width-1:0] B_OUT;
    logic             B_VALID;
    logic             UP;
    logic             DN;
    logic             STEP_ERR;
    logic             LOCK;
    logic [ERR_W-1:0] ERR_CNT;

    int checks = 0;
    int errors = 0;

    // Reference model state, one step per clock edge
    int mPendV, mPendB;
    int mHasPrev, mPrev;
    int mBOut, mBValid, mUp, mDn, mErr, mLock, mErrCnt;
    int lastBin = 0;

    gray_bin_decoder #(.Width(Width), .ERR_W(ERR_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .G_IN(G_IN),
        .G_VALID(G_VALID),
        .CLR_ERR(CLR_ERR),
        .B_OUT(B_OUT),
        .B_VALID(B_VALID),
        .UP(UP),
        .DN(DN),
        .STEP_ERR(STEP_ERR),
        .LOCK(LOCK),
        .ERR_CNT(ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int toGray(input int b);
        return (b ^ (b >> 1)) & Mask;
    endfunction

    // Decode by finding the code word in the table of all Gray codes
    function automatic int fromGray(input int g);
        for (int c = 0; c <= Mask; c++) begin
            if (toGray(c) == g) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelEdge(input int gIn, input int gValid, input int clrErr, input int rst);
        int d;
        if (rst != 0) begin
            mPendV = 0; mPendB = 0; mHasPrev = 0; mPrev = 0;
            mBOut = 0; mBValid = 0; mUp = 0; mDn = 0; mErr = 0; mLock = 0; mErrCnt = 0;
            return;
        end
        mBValid = mPendV;
        mUp = 0; mDn = 0; mErr = 0;
        if (mPendV != 0) begin
            mBOut = mPendB;
            if (mHasPrev != 0) begin
                d = (mPendB - mPrev) & Mask;
                mUp  = (d == 1) ? 1 : 0;
                mDn  = (d == Mask) ? 1 : 0;
                mErr = (d != 0 && mUp == 0 && mDn == 0) ? 1 : 0;
            end
            mLock = (mErr != 0) ? 0 : 1;
            mPrev = mPendB;
            mHasPrev = 1;
        end
        if (clrErr != 0) mErrCnt = 0;
        else if (mErr != 0 && mErrCnt < ErrMax) mErrCnt++;
        mPendV = gValid;
        if (gValid != 0) mPendB = fromGray(gIn);
    endtask

    task automatic applyStimulus(input int gIn, input int gValid, input int clrErr, input int rst);
        @(negedge CLK);
        G_IN    = gIn[Width-1:0];
        G_VALID = gValid[0];
        CLR_ERR = clrErr[0];
        RST     = rst[0];
        @(posedge CLK);
        modelEdge(gIn, gValid, clrErr, rst);
        #1;
        checkOutput("B_VALID", B_VALID, mBValid);
        checkOutput("B_OUT", B_OUT, mBOut);
        checkOutput("UP", UP, mUp);
        checkOutput("DN", DN, mDn);
        checkOutput("STEP_ERR", STEP_ERR, mErr);
        checkOutput("LOCK", LOCK, mLock);
        checkOutput("ERR_CNT", ERR_CNT, mErrCnt);
    endtask

    task automatic sendBin(input int b);
        applyStimulus(toGray(b), 1, 0, 0);
        lastBin = b & Mask;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        G_IN = '0; G_VALID = 1'b0; CLR_ERR = 1'b0; RST = 1'b1;
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("rstLock", LOCK, 0);

        // Counting sequence 0..4
        for (int b = 0; b <= 4; b++) sendBin(b);
        idle(2);
        checkOutput("seqLast", B_OUT, 4);

        // Wrap up, wrap down, hold
        sendBin(7); sendBin(0);
        sendBin(0); sendBin(7);
        sendBin(7); sendBin(7);
        idle(2);

        // Illegal jump then recovery by a down-step
        sendBin(1); sendBin(6); sendBin(5);
        idle(2);

        // Saturate the error counter
        for (int i = 0; i < 300; i++) sendBin((i % 2 == 0) ? 0 : 4);
        idle(2);
        checkOutput("errSat", ERR_CNT, ErrMax);

        // Clear coincides with the edge that registers an error
        sendBin(0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("clrWins", ERR_CNT, 0);
        idle(1);

        // Gapped valid
        applyStimulus(toGray(3), 1, 0, 0);
        idle(2);
        applyStimulus(toGray(4), 1, 0, 0);
        idle(2);

        // Reset drops an in-flight sample
        sendBin(5);
        applyStimulus(0, 0, 0, 1);
        idle(2);
        checkOutput("rstDrop", B_VALID, 0);
        sendBin(2);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, nb, rst, clr, gv;
            rst = ($urandom_range(0, 199) == 0) ? 1 : 0;
            clr = ($urandom_range(0, 49) == 0) ? 1 : 0;
            gv  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       nb = lastBin;
                1:       nb = (lastBin + 1) & Mask;
                2:       nb = (lastBin - 1) & Mask;
                default: nb = $urandom_range(0, Mask);
            endcase
            applyStimulus(toGray(nb), gv, clr, rst);
            if (gv != 0) lastBin = nb;
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
